// File: rtl/dec_mpp_ctrl.sv
// ---------------------------------------------------------------------------
// dec_mpp_ctrl
//
// Sequencer for midpoint-prediction (MPP) block reconstruction. One block is
// 16 samples x 3 components. The controller accepts a per-block configuration
// (quantizer step and one midpoint per component). It then gathers the 48
// quantized residuals from the four substream multiplexers (three 32-bit beats
// per SSM). Finally it streams the reconstructed samples, four per beat, to the
// reconstruction buffer.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   i_cfg_valid / o_cfg_ready block configuration handshake (ready in IDLE)
//   i_cfg_step                quantizer step (left-shift amount, 0..7)
//   i_cfg_mid0..2             midpoint of components 0..2
//   i_ssmN_valid/o_ssmN_ready residual beat handshake, N = 0..3
//   i_ssmN_data               four signed 8-bit residuals, sample k at [8k+7:8k]
//   o_out_valid / i_out_ready reconstruction beat handshake
//   o_out_comp, o_out_grp     component and sample group of the current beat
//   o_out_data                four reconstructed samples, BITDEPTH bits each
//   o_busy                    high while collecting or reconstructing
// ---------------------------------------------------------------------------
module dec_mpp_ctrl #(
  parameter int BITDEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  // block configuration
  input  logic                    i_cfg_valid,
  output logic                    o_cfg_ready,
  input  logic [2:0]              i_cfg_step,
  input  logic [BITDEPTH-1:0]     i_cfg_mid0,
  input  logic [BITDEPTH-1:0]     i_cfg_mid1,
  input  logic [BITDEPTH-1:0]     i_cfg_mid2,
  // substream multiplexer residual beats
  input  logic                    i_ssm0_valid,
  output logic                    o_ssm0_ready,
  input  logic [31:0]             i_ssm0_data,
  input  logic                    i_ssm1_valid,
  output logic                    o_ssm1_ready,
  input  logic [31:0]             i_ssm1_data,
  input  logic                    i_ssm2_valid,
  output logic                    o_ssm2_ready,
  input  logic [31:0]             i_ssm2_data,
  input  logic                    i_ssm3_valid,
  output logic                    o_ssm3_ready,
  input  logic [31:0]             i_ssm3_data,
  // reconstruction output
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [1:0]              o_out_comp,
  output logic [1:0]              o_out_grp,
  output logic [4*BITDEPTH-1:0]   o_out_data,
  output logic                    o_busy
);

  // Largest representable sample, as a 17-bit signed value for the clip test.
  localparam logic signed [16:0] C_MAX_SAMPLE = 17'((1 << BITDEPTH) - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_RECON
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [3:0]         w_ssm_valid;
  logic [3:0]         w_ssm_ready;
  logic [3:0]         w_ssm_accept;
  logic [31:0]        w_ssm_data [0:3];

  logic [1:0]         r_cnt      [0:3];
  logic [1:0]         w_cnt_next [0:3];
  logic               w_all_done;

  logic [31:0]        r_buf [0:3][0:2];

  logic [2:0]         r_step;
  logic [BITDEPTH-1:0] r_mid [0:2];

  logic [1:0]         r_comp;
  logic [1:0]         r_grp;

  logic               w_cfg_hs;
  logic               w_out_hs;
  logic               w_last_beat;

  logic [1:0]         w_buf_idx;
  logic [1:0]         w_beat_idx;
  logic [31:0]        w_word;
  logic [BITDEPTH-1:0] w_mid;

  // Dequantize one residual, add the component midpoint and clip to the
  // sample range. The shift is done at 16 bits and the sum at 17 bits so
  // that the largest residual at the largest step cannot overflow.
  function automatic logic [BITDEPTH-1:0] f_recon(
    input logic [7:0]          res,
    input logic [2:0]          step,
    input logic [BITDEPTH-1:0] mid
  );
    logic signed [15:0] deq;
    logic signed [16:0] sum;
    deq = $signed({{8{res[7]}}, res}) <<< step;
    sum = $signed({deq[15], deq}) + $signed({{(17-BITDEPTH){1'b0}}, mid});
    if (sum[16]) begin
      f_recon = '0;
    end else if (sum > C_MAX_SAMPLE) begin
      f_recon = '1;
    end else begin
      f_recon = sum[BITDEPTH-1:0];
    end
  endfunction

  // Gather the four SSM ports into arrays so the per-SSM logic is one loop.
  assign w_ssm_valid   = {i_ssm3_valid, i_ssm2_valid, i_ssm1_valid, i_ssm0_valid};
  assign w_ssm_data[0] = i_ssm0_data;
  assign w_ssm_data[1] = i_ssm1_data;
  assign w_ssm_data[2] = i_ssm2_data;
  assign w_ssm_data[3] = i_ssm3_data;
  assign o_ssm0_ready  = w_ssm_ready[0];
  assign o_ssm1_ready  = w_ssm_ready[1];
  assign o_ssm2_ready  = w_ssm_ready[2];
  assign o_ssm3_ready  = w_ssm_ready[3];

  assign w_cfg_hs    = i_cfg_valid && o_cfg_ready;
  assign w_out_hs    = o_out_valid && i_out_ready;
  assign w_last_beat = (r_comp == 2'd2) && (r_grp == 2'd3);

  // Each SSM is accepted independently until it has delivered its three
  // beats. The collection is complete when every counter reaches three,
  // including the cycle in which the final beats arrive, so the look-ahead
  // counter values are used for the exit decision.
  always_comb begin
    w_ssm_ready  = '0;
    w_ssm_accept = '0;
    w_all_done   = 1'b1;
    for (int n = 0; n < 4; n++) begin
      w_ssm_ready[n]  = (r_state == ST_COLLECT) && (r_cnt[n] != 2'd3);
      w_ssm_accept[n] = w_ssm_valid[n] && w_ssm_ready[n];
      w_cnt_next[n]   = r_cnt[n] + {1'b0, w_ssm_accept[n]};
      if (w_cnt_next[n] != 2'd3) begin
        w_all_done = 1'b0;
      end
    end
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    w_state_next = r_state;
    o_cfg_ready  = 1'b0;
    o_out_valid  = 1'b0;
    o_busy       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_cfg_ready = 1'b1;
        if (i_cfg_valid) begin
          w_state_next = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        o_busy = 1'b1;
        if (w_all_done) begin
          w_state_next = ST_RECON;
        end
      end
      ST_RECON: begin
        o_busy      = 1'b1;
        o_out_valid = 1'b1;
        if (i_out_ready && w_last_beat) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State register, block configuration, beat counters and output position.
  // The position counter walks groups within a component, then components.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_step  <= '0;
      r_comp  <= '0;
      r_grp   <= '0;
      for (int n = 0; n < 4; n++) begin
        r_cnt[n] <= '0;
      end
      for (int c = 0; c < 3; c++) begin
        r_mid[c] <= '0;
      end
    end else begin
      r_state <= w_state_next;
      if (w_cfg_hs) begin
        r_step   <= i_cfg_step;
        r_mid[0] <= i_cfg_mid0;
        r_mid[1] <= i_cfg_mid1;
        r_mid[2] <= i_cfg_mid2;
        r_comp   <= '0;
        r_grp    <= '0;
        for (int n = 0; n < 4; n++) begin
          r_cnt[n] <= '0;
        end
      end else if (r_state == ST_COLLECT) begin
        for (int n = 0; n < 4; n++) begin
          r_cnt[n] <= w_cnt_next[n];
        end
      end
      if (w_out_hs) begin
        if (r_grp == 2'd3) begin
          r_grp  <= '0;
          r_comp <= (r_comp == 2'd2) ? 2'd0 : r_comp + 2'd1;
        end else begin
          r_grp  <= r_grp + 2'd1;
        end
      end
    end
  end

  // Residual storage. Its contents are irrelevant after a reset because a
  // full collection always precedes any read, so it carries no reset.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (w_ssm_accept[n]) begin
        r_buf[n][r_cnt[n]] <= w_ssm_data[n];
      end
    end
  end

  // Output datapath. SSM0 carries group 0 of every component, and SSM(c+1)
  // carries groups 1..3 of component c. Everything here comes from
  // registers only, so the beat holds steady while the sink stalls.
  always_comb begin
    w_buf_idx  = r_comp + 2'd1;
    w_beat_idx = r_grp - 2'd1;
    w_mid      = r_mid[r_comp];
    if (r_grp == 2'd0) begin
      w_word = r_buf[0][r_comp];
    end else begin
      w_word = r_buf[w_buf_idx][w_beat_idx];
    end
    o_out_data = '0;
    if (r_state == ST_RECON) begin
      for (int k = 0; k < 4; k++) begin
        o_out_data[k*BITDEPTH +: BITDEPTH] = f_recon(w_word[8*k +: 8], r_step, w_mid);
      end
    end
  end

  assign o_out_comp = r_comp;
  assign o_out_grp  = r_grp;

endmodule
